cavlc_coeff_buffer: RTL and testbench

- Downstream consumer of the CAVLC level decoder.
- Takes decoded levels, in reverse scan order, together with their run_before values. Places each into its 4x4 zigzag position and converts to raster order.
- Streams the 16 reconstructed coefficients per block to the inverse-transform stage over a valid/ready handshake.
- Ping-pong buffering lets one block fill while the previous block drains.

---
 rtl/cavlc_coeff_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_cavlc_coeff_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_buffer.sv
`timescale 1ns/1ps
// cavlc_coeff_buffer
// Collects CAVLC-decoded levels (reverse scan order, each tagged with its
// run_before), places them at their 4x4 zigzag positions and streams the 16
// raster-order coefficients of each block downstream. Two banks ping-pong, so
// one block can fill while the previous one drains.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   BlockStart            block header strobe; TotalCoeff/TotalZeros sampled
//   InReady               a BlockStart can be accepted this cycle
//   WrReq/LevelIn/RunBefore  one decoded level and the zeros preceding it
//   BlockDone             decoder signals end of block
//   CoeffValid/CoeffReady output handshake
//   CoeffOut/CoeffIdx/CoeffLast  raster coefficient, its index, idx==15 flag
//   Error                 sticky protocol/bitstream error, cleared by Reset
module cavlc_coeff_buffer #(
  parameter int LEVEL_W   = 13,
  parameter int NUM_COEFF = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      BlockStart,
  input  logic [4:0]                TotalCoeff,
  input  logic [3:0]                TotalZeros,
  output logic                      InReady,
  input  logic                      WrReq,
  input  logic signed [LEVEL_W-1:0] LevelIn,
  input  logic [3:0]                RunBefore,
  input  logic                      BlockDone,
  output logic                      CoeffValid,
  input  logic                      CoeffReady,
  output logic signed [LEVEL_W-1:0] CoeffOut,
  output logic [3:0]                CoeffIdx,
  output logic                      CoeffLast,
  output logic                      Error
);

  typedef enum logic {F_IDLE, F_FILL} fillState_t;
  typedef enum logic {D_IDLE, D_OUT}  drainState_t;

  fillState_t  fillState;
  drainState_t drainState;

  logic                      fillPtr;
  logic                      drainPtr;
  logic [1:0]                bankFull;
  logic [NUM_COEFF-1:0]      bankMask [2];
  logic signed [LEVEL_W-1:0] bankData [2][NUM_COEFF];

  // Scan position of the next level; goes negative once the runs are used up.
  logic signed [6:0] pos;
  logic [4:0]        remaining;

  logic [5:0]        hdrSum;
  logic              hdrOver;
  logic signed [6:0] startPos;
  logic signed [6:0] posNext;
  logic              wrAccept;
  logic [4:0]        remainAfter;

  function automatic logic [3:0] zigzag(input logic [3:0] scan);
    case (scan)
      4'd0:  return 4'd0;
      4'd1:  return 4'd1;
      4'd2:  return 4'd4;
      4'd3:  return 4'd8;
      4'd4:  return 4'd5;
      4'd5:  return 4'd2;
      4'd6:  return 4'd3;
      4'd7:  return 4'd6;
      4'd8:  return 4'd9;
      4'd9:  return 4'd12;
      4'd10: return 4'd13;
      4'd11: return 4'd10;
      4'd12: return 4'd7;
      4'd13: return 4'd11;
      4'd14: return 4'd14;
      default: return 4'd15;
    endcase
  endfunction

  // Entries never written in the current block read as zero via the mask.
  function automatic logic signed [LEVEL_W-1:0] readCoeff(input logic bank,
                                                          input logic [3:0] idx);
    return bankMask[bank][idx] ? bankData[bank][idx] : '0;
  endfunction

  assign InReady = (fillState == F_IDLE) && !bankFull[fillPtr];

  always_comb begin
    hdrSum      = 6'(TotalCoeff) + 6'(TotalZeros);
    hdrOver     = hdrSum > 6'd16;
    startPos    = hdrOver ? 7'sd15 : $signed({1'b0, hdrSum}) - 7'sd1;
    posNext     = pos - 7'sd1 - $signed({3'b000, RunBefore});
    wrAccept    = (fillState == F_FILL) && WrReq && (remaining != '0) && !pos[6];
    remainAfter = wrAccept ? remaining - 5'd1 : remaining;
  end

  always_ff @(posedge Clk) begin
    if (wrAccept) begin
      bankData[fillPtr][zigzag(pos[3:0])] <= LevelIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fillState   <= F_IDLE;
      drainState  <= D_IDLE;
      fillPtr     <= 1'b0;
      drainPtr    <= 1'b0;
      bankFull    <= '0;
      bankMask[0] <= '0;
      bankMask[1] <= '0;
      pos         <= '0;
      remaining   <= '0;
      CoeffValid  <= 1'b0;
      CoeffOut    <= '0;
      CoeffIdx    <= '0;
      CoeffLast   <= 1'b0;
      Error       <= 1'b0;
    end else begin
      // Fill side
      case (fillState)
        F_IDLE: begin
          if (BlockStart) begin
            if (InReady) begin
              bankMask[fillPtr] <= '0;
              if (TotalCoeff == '0) begin
                bankFull[fillPtr] <= 1'b1;
                fillPtr           <= ~fillPtr;
              end else begin
                pos       <= startPos;
                remaining <= TotalCoeff;
                fillState <= F_FILL;
                if (hdrOver) Error <= 1'b1;
              end
            end else begin
              Error <= 1'b1;
            end
          end
        end
        F_FILL: begin
          if (BlockStart) Error <= 1'b1;
          if (WrReq) begin
            if (wrAccept) begin
              bankMask[fillPtr][zigzag(pos[3:0])] <= 1'b1;
              pos       <= posNext;
              remaining <= remaining - 5'd1;
            end else begin
              Error <= 1'b1;
            end
          end
          // A same-cycle write is already folded into remainAfter.
          if (BlockDone) begin
            if (remainAfter != '0) Error <= 1'b1;
            bankFull[fillPtr] <= 1'b1;
            fillPtr           <= ~fillPtr;
            fillState         <= F_IDLE;
          end
        end
        default: fillState <= F_IDLE;
      endcase

      // Drain side
      case (drainState)
        D_IDLE: begin
          if (bankFull[drainPtr]) begin
            CoeffValid <= 1'b1;
            CoeffIdx   <= '0;
            CoeffOut   <= readCoeff(drainPtr, 4'd0);
            CoeffLast  <= 1'b0;
            drainState <= D_OUT;
          end
        end
        D_OUT: begin
          if (CoeffReady) begin
            if (CoeffLast) begin
              bankFull[drainPtr] <= 1'b0;
              drainPtr           <= ~drainPtr;
              CoeffIdx           <= '0;
              CoeffLast          <= 1'b0;
              // Chain straight into the other bank when it is already full.
              if (bankFull[~drainPtr]) begin
                CoeffOut <= readCoeff(~drainPtr, 4'd0);
              end else begin
                CoeffValid <= 1'b0;
                CoeffOut   <= '0;
                drainState <= D_IDLE;
              end
            end else begin
              CoeffIdx  <= CoeffIdx + 4'd1;
              CoeffOut  <= readCoeff(drainPtr, CoeffIdx + 4'd1);
              CoeffLast <= (CoeffIdx == 4'd14);
            end
          end
        end
        default: drainState <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_buffer.sv
`timescale 1ns/1ps
module tb_cavlc_coeff_buffer;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               BlockStart;
  logic [4:0]         TotalCoeff;
  logic [3:0]         TotalZeros;
  logic               InReady;
  logic               WrReq;
  logic signed [12:0] LevelIn;
  logic [3:0]         RunBefore;
  logic               BlockDone;
  logic               CoeffValid;
  logic               CoeffReady;
  logic signed [12:0] CoeffOut;
  logic [3:0]         CoeffIdx;
  logic               CoeffLast;
  logic               Error;

  always #5 Clk = ~Clk;

  cavlc_coeff_buffer #(.LEVEL_W(13), .NUM_COEFF(16)) dut (
    .Clk(Clk), .Reset(Reset), .BlockStart(BlockStart), .TotalCoeff(TotalCoeff),
    .TotalZeros(TotalZeros), .InReady(InReady), .WrReq(WrReq), .LevelIn(LevelIn),
    .RunBefore(RunBefore), .BlockDone(BlockDone), .CoeffValid(CoeffValid),
    .CoeffReady(CoeffReady), .CoeffOut(CoeffOut), .CoeffIdx(CoeffIdx),
    .CoeffLast(CoeffLast), .Error(Error)
  );

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int readyMode = 0;   // 0: always ready, 1: toggle, 2: random
  bit expErr = 1'b0;
  int lvl[32];
  int rb[32];
  int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Downstream backpressure generator
  initial begin
    CoeffReady = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      case (readyMode)
        0:       CoeffReady = 1'b1;
        1:       CoeffReady = ~CoeffReady;
        default: CoeffReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard, hold-stability and back-to-back checks
  initial begin
    int  expIdx;
    int  e;
    bit  hold;
    bit  lastPending;
    bit  moreQueued;
    int  hOut, hIdx, hLast;
    expIdx = 0; hold = 0; lastPending = 0; moreQueued = 0;
    hOut = 0; hIdx = 0; hLast = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        expQ.delete();
        expIdx = 0; hold = 0; lastPending = 0;
      end else begin
        if (lastPending) begin
          if (moreQueued) begin
            checkVal("no_bubble_valid", CoeffValid, 1);
            checkVal("no_bubble_idx", CoeffIdx, 0);
          end else begin
            checkVal("idle_after_last", CoeffValid, 0);
          end
          lastPending = 0;
        end else if (hold) begin
          checkVal("hold_valid", CoeffValid, 1);
          checkVal("hold_out", $signed(CoeffOut), hOut);
          checkVal("hold_idx", CoeffIdx, hIdx);
          checkVal("hold_last", CoeffLast, hLast);
        end
        hold = 0;
        if (CoeffValid && CoeffReady) begin
          if (expQ.size() == 0) begin
            checkVal("spurious_valid", CoeffValid, 0);
          end else begin
            e = expQ.pop_front();
            checkVal("coeff_value", $signed(CoeffOut), e);
            checkVal("coeff_idx", CoeffIdx, expIdx);
            checkVal("coeff_last", CoeffLast, (expIdx == 15) ? 1 : 0);
            if (expIdx == 15) begin
              lastPending = 1;
              moreQueued  = (expQ.size() != 0);
            end
            expIdx = (expIdx + 1) % 16;
          end
        end else if (CoeffValid) begin
          hold  = 1;
          hOut  = $signed(CoeffOut);
          hIdx  = CoeffIdx;
          hLast = CoeffLast;
        end
      end
    end
  end

  // Reference: place levels by scan position from the header and runs,
  // then queue the 16 raster values once the DUT holds the block.
  task automatic runBlock(input int tc, input int tz, input int n,
                          input bit together, input bit chkLat);
    int raster[16];
    int pos;
    int remain;
    int w;
    bit err;
    for (int i = 0; i < 16; i++) raster[i] = 0;
    err = 0;
    if (tc + tz > 16) begin
      err = 1;
      pos = 15;
    end else begin
      pos = tc + tz - 1;
    end
    remain = tc;
    for (int k = 0; k < n; k++) begin
      if (remain == 0 || pos < 0) begin
        err = 1;
      end else begin
        raster[zz[pos]] = lvl[k];
        pos    = pos - 1 - rb[k];
        remain = remain - 1;
      end
    end
    if (tc != 0 && remain != 0) err = 1;

    w = 0;
    while (!InReady && w < 400) begin
      tick();
      w++;
    end
    if (!InReady) begin
      checkVal("inready_wait", InReady, 1);
      return;
    end

    BlockStart = 1'b1;
    TotalCoeff = 5'(tc);
    TotalZeros = 4'(tz);
    tick();
    BlockStart = 1'b0;
    if (tc != 0) begin
      for (int k = 0; k < n; k++) begin
        WrReq     = 1'b1;
        LevelIn   = 13'(lvl[k]);
        RunBefore = 4'(rb[k]);
        if (together && k == n - 1) BlockDone = 1'b1;
        tick();
        WrReq     = 1'b0;
        BlockDone = 1'b0;
      end
      if (!together || n == 0) begin
        BlockDone = 1'b1;
        tick();
        BlockDone = 1'b0;
      end
    end
    if (err) expErr = 1'b1;
    for (int i = 0; i < 16; i++) expQ.push_back(raster[i]);
    checkVal("error_flag", Error, expErr);

    if (chkLat) begin
      @(negedge Clk);
      checkVal("lat_t1_valid", CoeffValid, 0);
      tick();
      @(negedge Clk);
      checkVal("lat_t2_valid", CoeffValid, 1);
      checkVal("lat_t2_idx", CoeffIdx, 0);
      tick();
    end
  endtask

  task automatic waitDrained();
    int w;
    w = 0;
    while ((expQ.size() != 0 || CoeffValid) && w < 2000) begin
      tick();
      w++;
    end
    checkVal("drain_complete", expQ.size(), 0);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick();
    tick();
    Reset  = 1'b0;
    expErr = 1'b0;
  endtask

  task automatic genLegal(output int tc, output int tz);
    int zerosLeft;
    int r;
    tc = $urandom_range(1, 16);
    tz = $urandom_range(0, 16 - tc);
    zerosLeft = tz;
    for (int k = 0; k < tc; k++) begin
      if (k == tc - 1) r = zerosLeft;
      else r = $urandom_range(0, zerosLeft);
      zerosLeft = zerosLeft - r;
      rb[k]  = r;
      lvl[k] = int'($urandom_range(0, 8190)) - 4095;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, tz, w;
    Reset = 1'b1; BlockStart = 0; TotalCoeff = 0; TotalZeros = 0;
    WrReq = 0; LevelIn = 0; RunBefore = 0; BlockDone = 0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    checkVal("rst_inready", InReady, 1);
    checkVal("rst_valid", CoeffValid, 0);
    checkVal("rst_out", $signed(CoeffOut), 0);
    checkVal("rst_idx", CoeffIdx, 0);
    checkVal("rst_last", CoeffLast, 0);
    checkVal("rst_error", Error, 0);
    tick();

    // Nominal: raster[5]=1, raster[8]=-2, raster[1]=5
    readyMode = 0;
    lvl[0] = 1;  rb[0] = 0;
    lvl[1] = -2; rb[1] = 1;
    lvl[2] = 5;  rb[2] = 1;
    runBlock(3, 2, 3, 0, 1);
    waitDrained();

    // All-zero block
    runBlock(0, 0, 0, 0, 0);
    checkVal("zero_inready", InReady, 1);
    waitDrained();

    // Full block, final write coincident with BlockDone
    for (int k = 0; k < 16; k++) begin
      lvl[k] = 16 - k;
      rb[k]  = 0;
    end
    runBlock(16, 0, 16, 1, 0);
    waitDrained();

    // Random legal blocks, issued back to back under varying backpressure
    repeat (8) begin
      readyMode = $urandom_range(0, 2);
      genLegal(tc, tz);
      runBlock(tc, tz, tc, 1'($urandom_range(0, 1)), 0);
    end
    waitDrained();

    // Ping-pong with toggling ready, then a BlockStart while both banks busy
    readyMode = 1;
    genLegal(tc, tz);
    runBlock(tc, tz, tc, 0, 0);
    lvl[0] = 3;  rb[0] = 1;
    lvl[1] = -1; rb[1] = 0;
    lvl[2] = 2;  rb[2] = 2;
    lvl[3] = -7; rb[3] = 0;
    runBlock(4, 3, 4, 0, 0);
    checkVal("inready_busy", InReady, 0);
    BlockStart = 1'b1;
    TotalCoeff = 5'd1;
    TotalZeros = 4'd0;
    tick();
    BlockStart = 1'b0;
    expErr = 1'b1;
    checkVal("ignored_start_error", Error, 1);
    w = 0;
    while (!InReady && w < 400) begin
      tick();
      w++;
    end
    checkVal("inready_after_drain", (InReady && expQ.size() <= 16) ? 1 : 0, 1);
    waitDrained();

    // Run overflow: second level dropped
    doReset();
    readyMode = 0;
    lvl[0] = 7;  rb[0] = 3;
    lvl[1] = -9; rb[1] = 0;
    runBlock(2, 0, 2, 0, 0);
    waitDrained();
    checkVal("overflow_error_sticky", Error, 1);

    // TotalCoeff=17: clamped start position
    doReset();
    readyMode = 1;
    for (int k = 0; k < 16; k++) begin
      lvl[k] = 100 * (k + 1) - 900;
      rb[k]  = 0;
    end
    runBlock(17, 0, 16, 1, 0);

    // Reset while the drain is at index 7
    w = 0;
    while (!(CoeffValid && CoeffIdx == 4'd7) && w < 200) begin
      tick();
      w++;
    end
    checkVal("reach_idx7", CoeffIdx, 7);
    Reset = 1'b1;
    tick();
    Reset  = 1'b0;
    expErr = 1'b0;
    @(negedge Clk);
    checkVal("midrst_valid", CoeffValid, 0);
    checkVal("midrst_inready", InReady, 1);
    checkVal("midrst_error", Error, 0);
    checkVal("midrst_idx", CoeffIdx, 0);
    tick();

    // Block after reset decodes normally from bank 0
    readyMode = 0;
    lvl[0] = 1;  rb[0] = 0;
    lvl[1] = -2; rb[1] = 1;
    lvl[2] = 5;  rb[2] = 1;
    runBlock(3, 2, 3, 0, 1);
    waitDrained();
    checkVal("final_error", Error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
